// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32I data-memory responder: funct3 width codes,
// responder FSM encoding, the 32-bit word type and a funct3 legality helper.
package rv32_mem_pkg;

    typedef logic [31:0] word_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } mem_state_t;

    // Unsigned loads have no store counterpart, so BU/HU are illegal with we=1.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load byte/half extraction with sign or zero extension. Trap on misalignment
// only when DMEM_MISALIGN_TRAP_EN is defined; otherwise the access is aligned down.
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] funct3,
    input  logic       we,
    input  word_t      wdata,
    input  word_t      rdata_word,
    output logic [3:0] byte_en,
    output word_t      wdata_lanes,
    output word_t      load_data,
    output logic       err
);

    logic [1:0]  lane;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // lane is the access offset after forcing natural alignment
        lane = addr_lo;
        case (funct3[1:0])
            2'b01:   lane = {addr_lo[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = addr_lo;
        endcase

`ifdef DMEM_MISALIGN_TRAP_EN
        err = !funct3_legal(funct3, we) || (lane != addr_lo);
`else
        err = !funct3_legal(funct3, we);
`endif

        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
        if (!we || err) begin
            byte_en = 4'b0000;
        end

        sel_byte = rdata_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = rdata_word;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = '0;
        endcase
        if (we || err) begin
            load_data = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding RV32I data-memory responder with configurable wait latency.
// Optional misalignment trapping is selected with DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output mem_state_t  dbg_state
);

    // DEPTH_WORDS is expected to be a power of two so the index slice wraps.
    localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_state_t       state;
    logic [3:0]       cnt;
    logic             we_q;
    logic [IDX_W+1:0] addr_q;
    word_t            wdata_q;
    logic [2:0]       funct3_q;

    word_t            mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    word_t            rd_word;
    logic [3:0]       byte_en;
    word_t            wdata_lanes;
    word_t            load_data;
    logic             err;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:IDX_W+2];
    assign idx              = addr_q[IDX_W+1:2];
    assign rd_word          = mem[idx];
    assign req_ready        = (state == ST_IDLE);
    assign dbg_state        = state;

    dmem_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .funct3      (funct3_q),
        .we          (we_q),
        .wdata       (wdata_q),
        .rdata_word  (rd_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data),
        .err         (err)
    );

    // Handshakes: a request transfers on a rising edge where req_valid & req_ready,
    // a response where resp_valid & resp_ready; a valid side holds its payload
    // stable until that edge, and the request payload is captured only then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr[IDX_W+1:0];
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        if (LATENCY == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    resp_rdata <= load_data;
                    resp_err   <= err;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed RV32I cases, backpressure,
// reset abort, randomized traffic and back-to-back throughput against a byte model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    rv32_mem_pkg::mem_state_t dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } op_t;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte-addressed memory) ----------------
    // Returns {err, rdata}; stores update the byte array.
    function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                                 input logic [2:0] f3, input logic [31:0] wd);
        int          size;
        int          base;
        logic        legal;
        logic [31:0] v;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        if (!legal) return {1'b1, 32'h0};
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr % 32'(DEPTH*4));
        if (base % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            return {1'b1, 32'h0};
`else
            base = base - (base % size);
`endif
        end
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[base+i] = wd[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
        if (!f3[2] && size < 4 && ref_mem[base+size-1][7]) v = v | (32'hFFFF_FFFF << (8*size));
        return {1'b0, v};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        @(negedge clk);
        // Scramble the now-ignored request fields.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic transact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, input int hold,
                            output logic [31:0] rd, output logic er, output int lat);
        bit ok;
        send_req(we, addr, f3, wd, ok);
        wait_resp(lat);
        if (!ok) lat = -1;
        repeat (hold) @(negedge clk);
        rd = resp_rdata;
        er = resp_err;
        release_resp();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (dbg_state !== rv32_mem_pkg::ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_directed();
        op_t         tbl[$];
        logic [31:0] rd;
        logic        er;
        int          lat;
        tbl.push_back('{1'b1, 32'h100,  3'b010, 32'hDEAD_BEEF, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h100,  3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h103,  3'b000, 32'h0000_0080, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h103,  3'b000, 32'h0,         32'hFFFF_FF80, 1'b0});
        tbl.push_back('{1'b0, 32'h103,  3'b100, 32'h0,         32'h0000_0080, 1'b0});
        tbl.push_back('{1'b0, 32'h100,  3'b010, 32'h0,         32'h80AD_BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h102,  3'b001, 32'h0,         32'hFFFF_80AD, 1'b0});
        tbl.push_back('{1'b0, 32'h100,  3'b101, 32'h0,         32'h0000_BEEF, 1'b0});
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl.push_back('{1'b0, 32'h102,  3'b010, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h101,  3'b001, 32'h0,         32'h0,         1'b1});
`else
        tbl.push_back('{1'b0, 32'h102,  3'b010, 32'h0,         32'h80AD_BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h101,  3'b001, 32'h0,         32'hFFFF_BEEF, 1'b0});
`endif
        tbl.push_back('{1'b0, 32'h100,  3'b011, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 32'h100,  3'b100, 32'h0000_0011, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h100,  3'b010, 32'h0,         32'h80AD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h102,  3'b001, 32'hAAAA_1234, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h100,  3'b010, 32'h0,         32'h1234_BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h1100, 3'b010, 32'h0,         32'h1234_BEEF, 1'b0});
        foreach (tbl[i]) begin
            void'(model_access(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd));
            transact(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, 0, rd, er, lat);
            n_cmp++; if (rd !== tbl[i].exp_d) begin n_bad++; $display("FAIL directed_rdata[%0d]: got %h expected %h", i, rd, tbl[i].exp_d); end
            n_cmp++; if (er !== tbl[i].exp_e) begin n_bad++; $display("FAIL directed_err[%0d]: got %b expected %b", i, er, tbl[i].exp_e); end
            n_cmp++; if (lat !== LAT + 2) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT + 2); end
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          lat;
        logic [32:0] m;
        m = model_access(1'b0, 32'h100, 3'b010, 32'h0);
        send_req(1'b0, 32'h100, 3'b010, 32'h0, ok);
        wait_resp(lat);
        n_cmp++; if (!ok || lat !== LAT + 2) begin n_bad++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT + 2); end
        // A competing store offered while the response is held must be ignored.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h100;
        req_funct3 = 3'b010;
        req_wdata  = 32'h5555_5555;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, resp_valid); end
            n_cmp++; if (resp_rdata !== m[31:0]) begin n_bad++; $display("FAIL bp_rdata[%0d]: got %h expected %h", c, resp_rdata, m[31:0]); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", c, req_ready); end
        end
        req_valid = 1'b0;
        release_resp();
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        logic [32:0] m;
        void'(model_access(1'b1, 32'h200, 3'b010, 32'h1111_1111));
        transact(1'b1, 32'h200, 3'b010, 32'h1111_1111, 0, rd, er, lat);
        void'(model_access(1'b0, 32'h100, 3'b010, 32'h0));
        transact(1'b0, 32'h100, 3'b010, 32'h0, 0, rd, er, lat);
        // This store is aborted while waiting, so the model never sees it.
        send_req(1'b1, 32'h200, 3'b010, 32'h2222_2222, ok);
        reset = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL abort_resp_rdata: got %h expected 00000000", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL abort_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (dbg_state !== rv32_mem_pkg::ST_IDLE) begin n_bad++; $display("FAIL abort_state: got %0d expected IDLE", dbg_state); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_req_ready: got %b expected 1", req_ready); end
        m = model_access(1'b0, 32'h200, 3'b010, 32'h0);
        transact(1'b0, 32'h200, 3'b010, 32'h0, 0, rd, er, lat);
        n_cmp++; if (rd !== m[31:0] || rd !== 32'h1111_1111) begin n_bad++; $display("FAIL abort_store_kept_out: got %h expected 11111111", rd); end
        n_cmp++; if (lat !== LAT + 2) begin n_bad++; $display("FAIL abort_latency: got %0d expected %0d", lat, LAT + 2); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [32:0] m;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            void'(model_access(1'b1, 32'h300 + 32'(4*w), 3'b010, wd));
            transact(1'b1, 32'h300 + 32'(4*w), 3'b010, wd, 0, rd, er, lat);
        end
        for (int t = 0; t < 60; t++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = {20'($urandom), 12'h300 + 12'($urandom_range(0, 63))};
            wd   = $urandom;
            m    = model_access(we, addr, f3, wd);
            exp_q.push_back(m[31:0]);
            exp_err_q.push_back(m[32]);
            transact(we, addr, f3, wd, $urandom_range(0, 2), rd, er, lat);
            n_cmp++; if (rd !== exp_q[0]) begin n_bad++; $display("FAIL random_rdata[%0d]: we=%b f3=%b addr=%h got %h expected %h", t, we, f3, addr, rd, exp_q[0]); end
            n_cmp++; if (er !== exp_err_q[0]) begin n_bad++; $display("FAIL random_err[%0d]: got %b expected %b", t, er, exp_err_q[0]); end
            n_cmp++; if (lat !== LAT + 2) begin n_bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d", t, lat, LAT + 2); end
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        int          accepted;
        int          got;
        int          last;
        int          cyc;
        bit          advance;
        logic [32:0] m;
        logic [31:0] e_d;
        logic        e_e;
        accepted = 0;
        got      = 0;
        last     = -1;
        cyc      = 0;
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = 32'h300 + 32'($urandom_range(0, 63));
        req_wdata  = $urandom;
        while (got < 8 && cyc < 400) begin
            advance = 1'b0;
            if (resp_valid) begin
                e_d = exp_q.pop_front();
                e_e = exp_err_q.pop_front();
                n_cmp++; if (resp_rdata !== e_d) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", got, resp_rdata, e_d); end
                n_cmp++; if (resp_err !== e_e) begin n_bad++; $display("FAIL b2b_err[%0d]: got %b expected %b", got, resp_err, e_e); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last !== LAT + 3) begin n_bad++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", got, cyc - last, LAT + 3); end
                end
                last = cyc;
                got++;
            end
            if (req_valid && req_ready) begin
                m = model_access(req_we, req_addr, req_funct3, req_wdata);
                exp_q.push_back(m[31:0]);
                exp_err_q.push_back(m[32]);
                accepted++;
                advance = 1'b1;
            end
            @(posedge clk);
            #1;
            if (advance) begin
                req_valid  = (accepted < 8);
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = 32'h300 + 32'($urandom_range(0, 63));
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d expected 8", got); end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
